// File: rtl/argon_pkg.sv
// Shared definitions for the ArgonALU control path: bus width, opcodes and
// the request sequencer's state encoding.
package argon_pkg;

    localparam int ARGON_BUS_W = 16;

    // Opcode values understood by ArgonALU.
    typedef enum logic [3:0] {
        ARGON_OP_PASS = 4'h0,
        ARGON_OP_ADD  = 4'h1,
        ARGON_OP_SUB  = 4'h2,
        ARGON_OP_AND  = 4'h3,
        ARGON_OP_OR   = 4'h4,
        ARGON_OP_XOR  = 4'h5
    } argon_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_A,
        ST_LD_B,
        ST_LD_F,
        ST_LD_OP,
        ST_RD_Y,
        ST_RD_F,
        ST_DONE
    } argon_seq_state_t;

endpackage

// File: rtl/argon_alu_sequencer_if.sv
// Request/response and ALU-bus bundle of the ArgonALU sequencer.
// Handshakes: a beat transfers on a rising edge where valid and ready are both
// high; valid and its payload stay stable until then, ready may not wait on valid.
interface argon_alu_sequencer_if #(
    parameter int OP_W = 4
);
    localparam int W = argon_pkg::ARGON_BUS_W;

    logic            i_req_valid;
    logic            o_req_ready;
    logic [W-1:0]    i_req_a;
    logic [W-1:0]    i_req_b;
    logic [OP_W-1:0] i_req_op;
    logic            i_req_ldF;
    logic [W-1:0]    i_req_f;

    logic            o_rsp_valid;
    logic            i_rsp_ready;
    logic [W-1:0]    o_rsp_y;
    logic [W-1:0]    o_rsp_f;
    logic            o_rsp_err;
    logic            o_busy;

    logic [W-1:0]    o_alu_bus;
    logic            o_latchA;
    logic            o_latchB;
    logic            o_latchF;
    logic            o_latchOp;
    logic            o_outputY;
    logic            o_outputF;
    logic [W-1:0]    i_alu_bus;
    logic            i_alu_bus_valid;

    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_req_op, i_req_ldF, i_req_f,
        input  i_rsp_ready, i_alu_bus, i_alu_bus_valid,
        output o_req_ready, o_rsp_valid, o_rsp_y, o_rsp_f, o_rsp_err, o_busy,
        output o_alu_bus, o_latchA, o_latchB, o_latchF, o_latchOp, o_outputY, o_outputF
    );

    modport master (
        output i_req_valid, i_req_a, i_req_b, i_req_op, i_req_ldF, i_req_f,
        output i_rsp_ready, i_alu_bus, i_alu_bus_valid,
        input  o_req_ready, o_rsp_valid, o_rsp_y, o_rsp_f, o_rsp_err, o_busy,
        input  o_alu_bus, o_latchA, o_latchB, o_latchF, o_latchOp, o_outputY, o_outputF
    );

endinterface

// File: rtl/argon_seq_timer.sv
// Saturating wait counter: clear wins over enable, expired is high once the
// count has reached LIMIT.
module argon_seq_timer #(
    parameter int LIMIT = 15
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(LIMIT));

endmodule

// File: rtl/argon_alu_sequencer.sv
// Serialises one ALU request onto the shared ArgonALU bus with latch strobes,
// then reads back Y and F and returns them on the response port.
module argon_alu_sequencer
    import argon_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    argon_alu_sequencer_if.slave  seqIf,
    output argon_seq_state_t      dbgState
);
    localparam int W = ARGON_BUS_W;

    argon_seq_state_t state;
    logic [W-1:0]     regB, regF, busOut, rspY, rspF;
    logic [OP_W-1:0]  regOp;
    logic             regLdF;
    logic             latchA, latchB, latchF, latchOp, outputY, outputF;
    logic             rspValid, rspErr;
    logic             inRead, timerClear, timerExpired;

    // The timer restarts on entry to each read state: it is held clear outside
    // them and cleared again when RD_Y hands over to RD_F.
    assign inRead     = (state == ST_RD_Y) || (state == ST_RD_F);
    assign timerClear = !inRead || ((state == ST_RD_Y) && seqIf.i_alu_bus_valid);

    argon_seq_timer #(.LIMIT(TIMEOUT - 1)) uTimer (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .clear   (timerClear),
        .enable  (inRead),
        .expired (timerExpired)
    );

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state    <= ST_IDLE;
            regB     <= '0;
            regF     <= '0;
            regOp    <= '0;
            regLdF   <= 1'b0;
            busOut   <= '0;
            latchA   <= 1'b0;
            latchB   <= 1'b0;
            latchF   <= 1'b0;
            latchOp  <= 1'b0;
            outputY  <= 1'b0;
            outputF  <= 1'b0;
            rspValid <= 1'b0;
            rspErr   <= 1'b0;
            rspY     <= '0;
            rspF     <= '0;
        end else begin
            // Strobes and bus are decoded from the next state, so each is a
            // clean register output and the bus is zero whenever no latch fires.
            busOut  <= '0;
            latchA  <= 1'b0;
            latchB  <= 1'b0;
            latchF  <= 1'b0;
            latchOp <= 1'b0;
            outputY <= 1'b0;
            outputF <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (seqIf.i_req_valid) begin
                        regB   <= seqIf.i_req_b;
                        regF   <= seqIf.i_req_f;
                        regOp  <= seqIf.i_req_op;
                        regLdF <= seqIf.i_req_ldF;
                        rspErr <= 1'b0;
                        busOut <= seqIf.i_req_a;
                        latchA <= 1'b1;
                        state  <= ST_LD_A;
                    end
                end
                ST_LD_A: begin
                    busOut <= regB;
                    latchB <= 1'b1;
                    state  <= ST_LD_B;
                end
                ST_LD_B: begin
                    if (regLdF) begin
                        busOut <= regF;
                        latchF <= 1'b1;
                        state  <= ST_LD_F;
                    end else begin
                        busOut  <= {{(W - OP_W){1'b0}}, regOp};
                        latchOp <= 1'b1;
                        state   <= ST_LD_OP;
                    end
                end
                ST_LD_F: begin
                    busOut  <= {{(W - OP_W){1'b0}}, regOp};
                    latchOp <= 1'b1;
                    state   <= ST_LD_OP;
                end
                ST_LD_OP: begin
                    outputY <= 1'b1;
                    state   <= ST_RD_Y;
                end
                ST_RD_Y: begin
                    if (seqIf.i_alu_bus_valid) begin
                        rspY    <= seqIf.i_alu_bus;
                        outputF <= 1'b1;
                        state   <= ST_RD_F;
                    end else if (timerExpired) begin
                        rspErr   <= 1'b1;
                        rspY     <= '0;
                        rspF     <= '0;
                        rspValid <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        outputY <= 1'b1;
                    end
                end
                ST_RD_F: begin
                    if (seqIf.i_alu_bus_valid) begin
                        rspF     <= seqIf.i_alu_bus;
                        rspValid <= 1'b1;
                        state    <= ST_DONE;
                    end else if (timerExpired) begin
                        rspErr   <= 1'b1;
                        rspY     <= '0;
                        rspF     <= '0;
                        rspValid <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        outputF <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (seqIf.i_rsp_ready) begin
                        rspValid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign seqIf.o_req_ready = (state == ST_IDLE);
    assign seqIf.o_busy      = (state != ST_IDLE);
    assign seqIf.o_rsp_valid = rspValid;
    assign seqIf.o_rsp_y     = rspY;
    assign seqIf.o_rsp_f     = rspF;
    assign seqIf.o_rsp_err   = rspErr;
    assign seqIf.o_alu_bus   = busOut;
    assign seqIf.o_latchA    = latchA;
    assign seqIf.o_latchB    = latchB;
    assign seqIf.o_latchF    = latchF;
    assign seqIf.o_latchOp   = latchOp;
    assign seqIf.o_outputY   = outputY;
    assign seqIf.o_outputF   = outputF;
    assign dbgState          = state;

endmodule

// File: tb/tb_argon_alu_sequencer.sv
// Bench for argon_alu_sequencer: behavioural ALU responder with programmable
// valid delay, per-cycle expected bus trace, directed and random requests.
module tb_argon_alu_sequencer;
    import argon_pkg::*;

    localparam int W       = 16;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;
    localparam int EW      = 24;

    logic i_Clk   = 1'b0;
    logic i_Reset = 1'b0;
    argon_seq_state_t dbgState;

    argon_alu_sequencer_if #(.OP_W(4)) seqIf();

    argon_alu_sequencer #(.OP_W(4), .TIMEOUT(TIMEOUT)) dut (
        .i_Clk    (i_Clk),
        .i_Reset  (i_Reset),
        .seqIf    (seqIf),
        .dbgState (dbgState)
    );

    // ---------------- clock ----------------
    always #5 i_Clk = ~i_Clk;

    // ---------------- checking ----------------
    int nCompared   = 0;
    int nMismatched = 0;
    logic [EW-1:0] exp_q[$];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // {req_ready, rsp_valid, latchA, latchB, latchF, latchOp, outputY, outputF, bus}
    function automatic logic [EW-1:0] observe();
        return {seqIf.o_req_ready, seqIf.o_rsp_valid, seqIf.o_latchA, seqIf.o_latchB,
                seqIf.o_latchF, seqIf.o_latchOp, seqIf.o_outputY, seqIf.o_outputF,
                seqIf.o_alu_bus};
    endfunction

    function automatic logic [EW-1:0] busyCycle(input logic [5:0] strobes, input logic [W-1:0] bus);
        return {1'b0, 1'b0, strobes, bus};
    endfunction

    // ---------------- ALU responder ----------------
    int yDelay = 0;
    int fDelay = 0;
    logic [W-1:0] aluY = '0;
    logic [W-1:0] aluF = '0;
    int respCnt = 0;
    int respSel = 0;

    always @(negedge i_Clk) begin
        int sel;
        int d;
        sel = seqIf.o_outputY ? 1 : (seqIf.o_outputF ? 2 : 0);
        if (sel != respSel) respCnt = 0;
        respSel = sel;
        if (sel == 0) begin
            // Noise while no enable is high; the sequencer must ignore it.
            seqIf.i_alu_bus_valid = 1'($urandom_range(0, 1));
            seqIf.i_alu_bus       = 16'($urandom);
        end else begin
            d = (sel == 1) ? yDelay : fDelay;
            seqIf.i_alu_bus_valid = (respCnt == d);
            seqIf.i_alu_bus       = (respCnt == d) ? ((sel == 1) ? aluY : aluF) : 16'($urandom);
            respCnt++;
        end
    end

    // Bus-safety monitor: never more than one strobe, bus idle when no latch.
    always @(negedge i_Clk) begin
        if (i_Reset) begin
            checkVal("oneHot", 32'($countones({seqIf.o_latchA, seqIf.o_latchB, seqIf.o_latchF,
                     seqIf.o_latchOp, seqIf.o_outputY, seqIf.o_outputF}) <= 1), 32'd1);
            if (!(seqIf.o_latchA || seqIf.o_latchB || seqIf.o_latchF || seqIf.o_latchOp))
                checkVal("busIdle", 32'(seqIf.o_alu_bus), 32'd0);
        end
    end

    // ---------------- driver ----------------
    task automatic runReq(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                          input logic ldF, input logic [W-1:0] f,
                          input logic [W-1:0] y, input logic [W-1:0] fv,
                          input int yd, input int fd, input int hold);
        bit yTo, fTo, errE;
        logic [W-1:0] expY, expF;
        logic [EW-1:0] e;
        int idx, waitCyc;

        // Expected trace: A, B, optional F, Op, then each read enable held for
        // its wait plus the capture cycle, or for the full timeout window.
        exp_q.delete();
        exp_q.push_back(busyCycle(6'b100000, a));
        exp_q.push_back(busyCycle(6'b010000, b));
        if (ldF) exp_q.push_back(busyCycle(6'b001000, f));
        exp_q.push_back(busyCycle(6'b000100, {12'h000, op}));
        yTo = (yd >= TIMEOUT);
        fTo = 1'b0;
        for (int i = 0; i < (yTo ? TIMEOUT : yd + 1); i++) exp_q.push_back(busyCycle(6'b000010, '0));
        if (!yTo) begin
            fTo = (fd >= TIMEOUT);
            for (int i = 0; i < (fTo ? TIMEOUT : fd + 1); i++) exp_q.push_back(busyCycle(6'b000001, '0));
        end
        errE = yTo || fTo;
        expY = errE ? '0 : y;
        expF = errE ? '0 : fv;

        yDelay = yd;
        fDelay = fd;
        aluY   = y;
        aluF   = fv;

        @(negedge i_Clk);
        waitCyc = 0;
        while (!seqIf.o_req_ready && waitCyc < 50) begin
            @(negedge i_Clk);
            waitCyc++;
        end
        checkVal("reqReadyIdle", 32'(seqIf.o_req_ready), 32'd1);
        seqIf.i_req_a     = a;
        seqIf.i_req_b     = b;
        seqIf.i_req_op    = op;
        seqIf.i_req_ldF   = ldF;
        seqIf.i_req_f     = f;
        seqIf.i_req_valid = 1'b1;
        seqIf.i_rsp_ready = 1'b0;
        @(posedge i_Clk);
        #1 seqIf.i_req_valid = 1'b0;

        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge i_Clk);
            e = exp_q.pop_front();
            checkVal($sformatf("cycle%0d", idx), 32'(observe()), 32'(e));
            idx++;
        end

        @(negedge i_Clk);
        checkVal("rspValid", 32'(seqIf.o_rsp_valid), 32'd1);
        checkVal("rspY", 32'(seqIf.o_rsp_y), 32'(expY));
        checkVal("rspF", 32'(seqIf.o_rsp_f), 32'(expF));
        checkVal("rspErr", 32'(seqIf.o_rsp_err), 32'(errE));

        for (int i = 0; i < hold; i++) begin
            // A competing request during backpressure must not be taken.
            seqIf.i_req_valid = 1'b1;
            seqIf.i_req_a     = 16'($urandom);
            seqIf.i_req_b     = 16'($urandom);
            @(negedge i_Clk);
            checkVal("holdValid", 32'(seqIf.o_rsp_valid), 32'd1);
            checkVal("holdY", 32'(seqIf.o_rsp_y), 32'(expY));
            checkVal("holdF", 32'(seqIf.o_rsp_f), 32'(expF));
            checkVal("holdReqReady", 32'(seqIf.o_req_ready), 32'd0);
            checkVal("holdState", 32'(dbgState), 32'(ST_DONE));
        end
        seqIf.i_req_valid = 1'b0;
        seqIf.i_rsp_ready = 1'b1;
        @(posedge i_Clk);
        #1;
        checkVal("rspDrop", 32'(seqIf.o_rsp_valid), 32'd0);
        checkVal("readyAfterRsp", 32'(seqIf.o_req_ready), 32'd1);
        seqIf.i_rsp_ready = 1'b0;
    endtask

    task automatic resetMidRead();
        yDelay = NEVER;
        @(negedge i_Clk);
        seqIf.i_req_a     = 16'hBEEF;
        seqIf.i_req_b     = 16'h0101;
        seqIf.i_req_op    = 4'h2;
        seqIf.i_req_ldF   = 1'b0;
        seqIf.i_req_valid = 1'b1;
        @(posedge i_Clk);
        #1 seqIf.i_req_valid = 1'b0;
        repeat (5) @(negedge i_Clk);
        checkVal("midRdY", 32'(dbgState), 32'(ST_RD_Y));
        #2 i_Reset = 1'b0;
        #1;
        checkVal("rstOutputs", 32'(observe()), 32'({1'b1, 1'b0, 6'b0, 16'h0000}));
        checkVal("rstState", 32'(dbgState), 32'(ST_IDLE));
        @(negedge i_Clk);
        i_Reset = 1'b1;
        @(posedge i_Clk);
        #1;
        checkVal("rstReleaseReady", 32'(seqIf.o_req_ready), 32'd1);
        checkVal("rstReleaseState", 32'(dbgState), 32'(ST_IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] ra, rb, rf;
        logic [3:0]   rop;
        int           ryd, rfd;

        seqIf.i_req_valid     = 1'b0;
        seqIf.i_req_a         = '0;
        seqIf.i_req_b         = '0;
        seqIf.i_req_op        = '0;
        seqIf.i_req_ldF       = 1'b0;
        seqIf.i_req_f         = '0;
        seqIf.i_rsp_ready     = 1'b0;
        seqIf.i_alu_bus       = '0;
        seqIf.i_alu_bus_valid = 1'b0;

        repeat (3) @(negedge i_Clk);
        checkVal("resetOutputs", 32'(observe()), 32'({1'b1, 1'b0, 6'b0, 16'h0000}));
        checkVal("resetState", 32'(dbgState), 32'(ST_IDLE));
        checkVal("resetRspY", 32'(seqIf.o_rsp_y), 32'd0);
        checkVal("resetRspF", 32'(seqIf.o_rsp_f), 32'd0);
        checkVal("resetErr", 32'(seqIf.o_rsp_err), 32'd0);
        i_Reset = 1'b1;

        runReq(16'h1234, 16'h0011, 4'h1, 1'b0, 16'h0000, 16'h1245, 16'h0000, 0, 0, 0);
        runReq(16'h1234, 16'h0011, 4'h1, 1'b1, 16'h0001, 16'h1246, 16'h0002, 0, 0, 0);
        runReq(16'hA5A5, 16'h0F0F, 4'h3, 1'b0, 16'h0000, 16'h0505, 16'h8000, 3, 2, 0);
        runReq(16'h7777, 16'h1111, 4'h2, 1'b0, 16'h0000, 16'h6666, 16'h0000, NEVER, 0, 0);
        runReq(16'h0003, 16'h0004, 4'h1, 1'b0, 16'h0000, 16'h0007, 16'h0000, 0, 0, 0);
        runReq(16'hFFFF, 16'h0001, 4'h1, 1'b1, 16'h00F0, 16'h0000, 16'h0003, 1, 1, 5);
        runReq(16'h1000, 16'h2000, 4'h4, 1'b0, 16'h0000, 16'h3000, 16'h0000, 15, 15, 0);
        runReq(16'h0102, 16'h0304, 4'h5, 1'b0, 16'h0000, 16'h0206, 16'h0010, 1, NEVER, 2);

        resetMidRead();
        runReq(16'h4321, 16'h1111, 4'h1, 1'b0, 16'h0000, 16'h5432, 16'h0000, 0, 0, 0);

        for (int n = 0; n < 25; n++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rf  = 16'($urandom);
            rop = 4'($urandom_range(0, 15));
            ryd = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 4);
            rfd = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 4);
            runReq(ra, rb, rop, 1'($urandom_range(0, 1)), rf, ra + rb, 16'($urandom),
                   ryd, rfd, $urandom_range(0, 3));
        end

        repeat (2) @(negedge i_Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/argon_alu_sequencer.md
Name: argon_alu_sequencer

Overview:
- Upstream control stage for ArgonALU. Accepts one complete ALU request (operands, opcode, optional flags-in) over a valid/ready handshake.
- Serialises the request onto the ALU's shared 16-bit bus using the latch/output strobes, then reads back result Y and flags F.
- Returns Y and F on a valid/ready response port. Lets a core or testbench issue ALU ops without hand-driving strobes.

Parameters:
- OP_W, 4, opcode width; zero-extended to 16 bits on the bus during LD_OP.
- TIMEOUT, 16, max cycles to wait for i_alu_bus_valid in RD_Y or RD_F before flagging an error.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Reset  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  high only in IDLE.
- i_req_a  in  16  operand A.
- i_req_b  in  16  operand B.
- i_req_op  in  OP_W  ALU opcode.
- i_req_ldF  in  1  load flags before op.
- i_req_f  in  16  flags-in value, used when i_req_ldF=1.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response accept.
- o_rsp_y  out  16  captured Y.
- o_rsp_f  out  16  captured F.
- o_rsp_err  out  1  timeout occurred.
- o_busy  out  1  state != IDLE.
- o_alu_bus  out  16  data driven to ALU i_bus.
- o_latchA, o_latchB, o_latchF, o_latchOp  out  1 each  ALU latch strobes.
- o_outputY, o_outputF  out  1 each  ALU output enables.
- i_alu_bus  in  16  ALU o_bus.
- i_alu_bus_valid  in  1  ALU o_bus_valid.

Behaviour:
- Reset (async, i_Reset=0): state IDLE; all strobes, o_rsp_valid, o_rsp_err = 0; o_rsp_y = o_rsp_f = 0; o_alu_bus = 0; timeout counter = 0. Applies mid-operation; the in-flight request is dropped.
- States: IDLE, LD_A, LD_B, LD_F, LD_OP, RD_Y, RD_F, DONE.
- IDLE: when i_req_valid & o_req_ready, register a, b, op, ldF, f, then go to LD_A.
- LD_A: o_alu_bus=a, o_latchA=1 for one cycle, then LD_B.
- LD_B: o_alu_bus=b, o_latchB=1 for one cycle, then LD_F if ldF, else LD_OP.
- LD_F: o_alu_bus=f, o_latchF=1 for one cycle, then LD_OP.
- LD_OP: o_alu_bus={zero, op}, o_latchOp=1 for one cycle, then RD_Y.
- RD_Y: o_outputY=1 held.
  - On a cycle with i_alu_bus_valid=1: capture i_alu_bus into Y, go to RD_F.
  - If TIMEOUT cycles elapse without valid: set err, Y=F=0, go to DONE.
- RD_F: same rules with o_outputF, capturing into F, then DONE.
- DONE: o_rsp_valid=1, outputs held stable until i_rsp_ready=1. Then clear valid and go to IDLE; err clears on the next accept.
- Strobe and bus rules:
  - Strobes are registered (Moore) outputs.
  - At most one strobe or enable high in any cycle.
  - o_alu_bus = 0 whenever no latch strobe is high, so the shared bus is never contended.
- Timeout counter: resets on entry to RD_Y and RD_F; saturates; counts cycles in state.
- Latency, accept edge = cycle 0, ALU valid on the first output cycle:
  - o_rsp_valid rises after edge 5 without ldF, after edge 6 with ldF.
  - Each extra ALU wait cycle adds 1.
- Throughput: one request in flight. o_req_ready=0 from accept until the response handshake completes.
- Response-ready boundary: i_rsp_ready high in the same cycle DONE is entered completes the handshake at the next edge; minimum 1 cycle of valid.
- i_alu_bus_valid outside RD_Y/RD_F is ignored.

Decomposition:
- Shared package argon_pkg holds:
  - state enum argon_seq_state_t;
  - ARGON_BUS_W=16;
  - opcode constants shared with ArgonALU.
- One natural sub-module: argon_seq_timer, a saturating wait counter with clear/enable and an expired flag, reusable by other bus masters. Everything else stays in one FSM.

Test Plan:
- Bench setup: behavioural ALU responder with programmable valid delay.
- Basic op: req a=16'h1234, b=16'h0011, op=4'h1, ldF=0; ALU returns Y=16'h1245, F=16'h0000 with 0 delay.
  - Required: strobe order A, B, Op, Y, F.
  - Required: bus carries 1234 then 0011 then 0001.
  - Required: o_rsp_valid after edge 5; rsp_y=1245, rsp_f=0, err=0.
- Flags load: ldF=1, f=16'h0001.
  - Required: o_latchF pulses with bus=0001 between latchB and latchOp; rsp_valid after edge 6.
- Slow ALU: valid delayed 3 cycles in RD_Y and 2 cycles in RD_F.
  - Required: outputY held for 4 cycles and outputF for 3; latency 10; correct capture.
- Timeout: ALU never asserts valid.
  - Required: outputY high exactly 16 cycles, then DONE with err=1, y=f=0.
  - Required: next request completes normally with err=0.
- Backpressure: i_rsp_ready held low 5 cycles.
  - Required: rsp_valid/y/f stable; o_req_ready=0 throughout; new i_req_valid not accepted until after the handshake.
- Async reset: assert i_Reset=0 mid-RD_Y.
  - Required: all strobes and rsp_valid low immediately, state IDLE, o_req_ready=1 after release.
  - Required: one-hot strobe assertion holds in every cycle of all tests.
